// File: rtl/control_pasos_frec_pkg.sv
// Shared constants for the frequency-step controller: state encodings, level range,
// default millisecond timings and the saturating step helper.
package control_pasos_frec_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_STEP     = 3'd2,
    S_HOLD     = 3'd3,
    S_REPEAT   = 3'd4,
    S_SWEEP    = 3'd5
  } estado_t;

  localparam logic [2:0] NIVEL_MAX = 3'd7;
  localparam int TMR_W = 10;

  localparam int DEB_MS_DEF   = 20;
  localparam int REP_DLY_DEF  = 500;
  localparam int REP_MS_DEF   = 200;
  localparam int SWEEP_MS_DEF = 1000;

  // {up, down} command for a step in direction 'up', dropped at the range ends
  function automatic logic [1:0] paso_cmd(input logic up, input logic [2:0] niv);
    return {up && (niv != NIVEL_MAX), !up && (niv != 3'd0)};
  endfunction

endpackage

// File: rtl/control_pasos_frec_temporizador_ms.sv
// Shared millisecond timer: counts tick strobes and flags the one that reaches limite,
// then restarts so a state can use it as a periodic timebase.
module temporizador_ms
  import control_pasos_frec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic [TMR_W-1:0] limite,
  output logic             fin
);

  logic [TMR_W-1:0] cnt;

  // A tick during clear is dropped, so the state-entry cycle never counts
  assign fin = tick && !clear && (cnt == limite - TMR_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else if (fin)   cnt <= '0;
    else if (tick)  cnt <= cnt + TMR_W'(1);
  end

endmodule

// File: rtl/control_pasos_frec.sv
// Step controller: debounces up/down buttons, auto-repeats on hold and runs a
// triangular sweep of the 3-bit level, emitting one-cycle step commands.
module control_pasos_frec
  import control_pasos_frec_pkg::*;
#(
  parameter int DEB_MS   = DEB_MS_DEF,
  parameter int REP_DLY  = REP_DLY_DEF,
  parameter int REP_MS   = REP_MS_DEF,
  parameter int SWEEP_MS = SWEEP_MS_DEF
) (
  input  logic       CLK_100MHz,
  input  logic       reset,
  input  logic       tick_1kHz,
  input  logic       aumentar,
  input  logic       disminuir,
  input  logic       funct_select,
  input  logic       modo_barrido,
  input  logic [2:0] nivel,
  output logic       paso_up,
  output logic       paso_down,
  output logic       ocupado,
  output logic [2:0] estado
);

  estado_t          state;
  logic             dir_up;
  logic             sweep_up;
  logic             clear_q;
  logic             clear_t;
  logic             fin;
  logic             held_ok;
  logic             sweep_dir;
  logic [TMR_W-1:0] limite;

  // Latched button still alone; releasing it or adding the other one both fail this
  assign held_ok   = dir_up ? (aumentar && !disminuir) : (disminuir && !aumentar);
  assign sweep_dir = (nivel == NIVEL_MAX) ? 1'b0 :
                     (nivel == 3'd0)      ? 1'b1 : sweep_up;

  always_comb begin
    limite = '0;
    case (state)
      S_DEBOUNCE: limite = TMR_W'(DEB_MS);
      S_HOLD:     limite = TMR_W'(REP_DLY);
      S_REPEAT:   limite = TMR_W'(REP_MS);
      S_SWEEP:    limite = TMR_W'(SWEEP_MS);
      default:    limite = '0;
    endcase
  end

  assign clear_t = clear_q || (state == S_IDLE) || (state == S_STEP);

  temporizador_ms u_tmr (
    .clk    (CLK_100MHz),
    .rst    (reset),
    .tick   (tick_1kHz),
    .clear  (clear_t),
    .limite (limite),
    .fin    (fin)
  );

  assign estado  = state;
  assign ocupado = (state != S_IDLE);

  // clear_q is raised on every transition so the new state starts from a fresh count
  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dir_up    <= 1'b1;
      sweep_up  <= 1'b1;
      clear_q   <= 1'b0;
      paso_up   <= 1'b0;
      paso_down <= 1'b0;
    end else begin
      paso_up   <= 1'b0;
      paso_down <= 1'b0;
      clear_q   <= 1'b0;
      if (funct_select) begin
        state   <= S_IDLE;
        clear_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (modo_barrido) begin
              state   <= S_SWEEP;
              clear_q <= 1'b1;
            end else if (aumentar != disminuir) begin
              state   <= S_DEBOUNCE;
              dir_up  <= aumentar;
              clear_q <= 1'b1;
            end
          end
          S_DEBOUNCE: begin
            if (!held_ok) begin
              state   <= S_IDLE;
              clear_q <= 1'b1;
            end else if (fin) begin
              // pulse is driven while in STEP, one cycle after the qualifying tick
              state                <= S_STEP;
              clear_q              <= 1'b1;
              {paso_up, paso_down} <= paso_cmd(dir_up, nivel);
            end
          end
          S_STEP: begin
            state   <= S_HOLD;
            clear_q <= 1'b1;
          end
          S_HOLD: begin
            if (!held_ok) begin
              state   <= S_IDLE;
              clear_q <= 1'b1;
            end else if (fin) begin
              state                <= S_REPEAT;
              clear_q              <= 1'b1;
              {paso_up, paso_down} <= paso_cmd(dir_up, nivel);
            end
          end
          S_REPEAT: begin
            if (!held_ok) begin
              state   <= S_IDLE;
              clear_q <= 1'b1;
            end else if (fin) begin
              {paso_up, paso_down} <= paso_cmd(dir_up, nivel);
            end
          end
          S_SWEEP: begin
            if (!modo_barrido) begin
              state   <= S_IDLE;
              clear_q <= 1'b1;
            end else if (fin) begin
              sweep_up             <= sweep_dir;
              {paso_up, paso_down} <= {sweep_dir, !sweep_dir};
            end
          end
          default: begin
            state   <= S_IDLE;
            clear_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_pasos_frec.sv
// Randomised and directed bench for control_pasos_frec with an action/tick-window
// reference model and a per-cycle output compare.
module tb_control_pasos_frec;

  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 4;
  localparam int SWP  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       aum, dis, fs, mb;
  logic [2:0] niv;
  logic       paso_up, paso_down, ocupado;
  logic [2:0] estado;

  int  checks = 0;
  int  failures = 0;
  int  n_up = 0;
  int  n_dn = 0;
  bit  rnd_tick = 1'b0;
  int  tc = 0;

  // reference model state: one "action" (button or sweep) with tick windows
  bit  m_act, m_sw, m_up, m_swup, m_nochk;
  int  m_stage, m_cnt, m_blind;
  bit  e_up, e_dn;

  control_pasos_frec #(
    .DEB_MS(DEB), .REP_DLY(RDLY), .REP_MS(RPER), .SWEEP_MS(SWP)
  ) dut (
    .CLK_100MHz   (clk),
    .reset        (rst),
    .tick_1kHz    (tick),
    .aumentar     (aum),
    .disminuir    (dis),
    .funct_select (fs),
    .modo_barrido (mb),
    .nivel        (niv),
    .paso_up      (paso_up),
    .paso_down    (paso_down),
    .ocupado      (ocupado),
    .estado       (estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One edge of the model. Window lengths: debounce DEB ticks, then hold RDLY, then
  // every RPER; 'blind' edges are the cycles whose ticks the controller cannot count.
  task automatic model_step();
    bit ok, eff;
    int goal;
    e_up = 1'b0;
    e_dn = 1'b0;
    if (rst) begin
      m_act = 1'b0;
      m_swup = 1'b1;
      return;
    end
    if (fs) m_act = 1'b0;
    else if (!m_act) begin
      if (mb) begin
        m_act = 1'b1; m_sw = 1'b1; m_cnt = 0; m_blind = 1;
      end else if (aum != dis) begin
        m_act = 1'b1; m_sw = 1'b0; m_up = aum; m_stage = 0;
        m_cnt = 0; m_blind = 1; m_nochk = 1'b0;
      end
    end else if (m_sw) begin
      if (!mb) m_act = 1'b0;
      else if (m_blind > 0) m_blind--;
      else if (tick) begin
        m_cnt++;
        if (m_cnt == SWP) begin
          m_cnt = 0;
          eff = (niv == 3'd7) ? 1'b0 : (niv == 3'd0) ? 1'b1 : m_swup;
          m_swup = eff;
          e_up = eff;
          e_dn = !eff;
        end
      end
    end else begin
      ok = m_up ? (aum && !dis) : (dis && !aum);
      if (!ok && !m_nochk) m_act = 1'b0;
      else begin
        m_nochk = 1'b0;
        goal = (m_stage == 0) ? DEB : (m_stage == 1) ? RDLY : RPER;
        if (m_blind > 0) m_blind--;
        else if (tick) begin
          m_cnt++;
          if (m_cnt == goal) begin
            m_cnt = 0;
            e_up = m_up && (niv != 3'd7);
            e_dn = !m_up && (niv != 3'd0);
            if (m_stage == 0) begin
              m_stage = 1; m_blind = 2; m_nochk = 1'b1;
            end else if (m_stage == 1) begin
              m_stage = 2; m_blind = 1;
            end
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    tick = rnd_tick ? ($urandom_range(0, 3) == 0) : ((tc % 4) == 0);
    tc++;
  end

  // compare, then close the loop: the bench plays the up/down counter driving nivel
  initial forever begin
    @(negedge clk);
    chk("paso_up", paso_up, e_up);
    chk("paso_down", paso_down, e_dn);
    chk("ocupado", ocupado, m_act);
    chk("paso_exclusive", paso_up & paso_down, 0);
    if (paso_up) n_up++;
    if (paso_down) n_dn++;
    if (e_up) niv = niv + 3'd1;
    if (e_dn) niv = niv - 3'd1;
  end

  task automatic clr_cnt();
    n_up = 0;
    n_dn = 0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; aum = 1'b0; dis = 1'b0; fs = 1'b0; mb = 1'b0; niv = 3'd0;
    cyc(3);
    chk("rst_paso_up", paso_up, 0);
    chk("rst_paso_down", paso_down, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_estado", estado, 0);
    rst = 1'b0;
    cyc(4);

    // short press: one step only
    niv = 3'd3; clr_cnt();
    aum = 1'b1; cyc(32); aum = 1'b0; cyc(8);
    chk("press_up_count", n_up, 1);
    chk("press_dn_count", n_dn, 0);
    chk("press_nivel", niv, 4);
    chk("press_idle", ocupado, 0);

    // bounce shorter than the debounce window
    clr_cnt();
    repeat (3) begin
      aum = 1'b1; cyc(8); aum = 1'b0; cyc(8);
    end
    cyc(8);
    chk("bounce_count", n_up + n_dn, 0);

    // long hold down from 5: debounce, hold delay, then repeats
    niv = 3'd5; clr_cnt();
    dis = 1'b1; cyc(112); dis = 1'b0; cyc(8);
    chk("hold_dn_count", n_dn, 5);
    chk("hold_up_count", n_up, 0);
    chk("hold_nivel", niv, 0);

    // same hold at the bottom: all steps suppressed
    niv = 3'd0; clr_cnt();
    dis = 1'b1; cyc(60);
    chk("sat_busy", ocupado, 1);
    cyc(52); dis = 1'b0; cyc(8);
    chk("sat_count", n_up + n_dn, 0);
    chk("sat_nivel", niv, 0);

    // sweep from 6: 7,6,5,4,3,2,1,0,1
    niv = 3'd6; clr_cnt();
    mb = 1'b1; cyc(20);
    chk("sweep_estado", estado, 5);
    cyc(172); mb = 1'b0; cyc(4);
    chk("sweep_up_count", n_up, 2);
    chk("sweep_dn_count", n_dn, 7);
    chk("sweep_nivel", niv, 1);
    chk("sweep_idle", ocupado, 0);

    // funct_select in the middle of auto-repeat
    niv = 3'd0; clr_cnt();
    aum = 1'b1; cyc(80);
    chk("repeat_estado", estado, 4);
    fs = 1'b1; cyc(4);
    chk("fs_idle", ocupado, 0);
    aum = 1'b0; cyc(2); fs = 1'b0; cyc(20);
    chk("fs_up_count", n_up, 3);
    chk("fs_nivel", niv, 3);

    // asynchronous reset during debounce
    clr_cnt();
    aum = 1'b1; cyc(6);
    rst = 1'b1; #1;
    chk("arst_ocupado", ocupado, 0);
    chk("arst_estado", estado, 0);
    aum = 1'b0; cyc(2); rst = 1'b0; cyc(20);
    chk("arst_count", n_up + n_dn, 0);

    // both buttons together
    clr_cnt();
    aum = 1'b1; dis = 1'b1; cyc(60);
    chk("both_idle", ocupado, 0);
    aum = 1'b0; dis = 1'b0; cyc(4);
    chk("both_count", n_up + n_dn, 0);

    // random phase
    rnd_tick = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) aum = ~aum;
      if ($urandom_range(0, 39) == 0) dis = ~dis;
      if (fs) begin
        if ($urandom_range(0, 19) == 0) fs = 1'b0;
      end else if ($urandom_range(0, 299) == 0) fs = 1'b1;
      if ($urandom_range(0, 299) == 0) mb = ~mb;
      if ($urandom_range(0, 199) == 0) niv = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1; cyc(1); rst = 1'b0;
      end
      cyc(1);
    end
    aum = 1'b0; dis = 1'b0; fs = 1'b0; mb = 1'b0;
    cyc(10);
    chk("final_idle", ocupado, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
